// File: rtl/digit_assembler.sv
// digit_assembler: packs 4-bit digits into a 16-bit word with commit/ack handshake and inactivity timeout
module digit_assembler #(
  parameter bit          MSD_FIRST      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TO_W           = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  digit_in,
  input  logic        digit_valid,
  input  logic        clear,
  input  logic        value_ack,
  output logic        ready,
  output logic [1:0]  dig_sel,
  output logic [15:0] entry,
  output logic [15:0] value_out,
  output logic        value_valid,
  output logic        timeout,
  output logic        overrun
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  localparam logic [1:0] START = MSD_FIRST ? 2'b11 : 2'b00;
  localparam logic [1:0] TERM = ~START;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [15:0] entry_q, entry_d, value_q, value_d;
  logic [1:0] sel_q, sel_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, overrun_q, overrun_d;
  logic accept, expire;
  assign ready = state_q != HOLD;
  assign accept = digit_valid & ready & ~clear;
  // a digit landing in the terminal-count cycle cancels the abort
  assign expire = (TIMEOUT_CYCLES != 0) && state_q == FILL && !accept && cnt_q == TO_LAST;
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    value_d = value_q;
    sel_d = sel_q;
    cnt_d = (TIMEOUT_CYCLES != 0 && state_q == FILL && !accept) ? cnt_q + 1'b1 : '0;
    timeout_d = expire & ~clear;
    overrun_d = digit_valid & ~ready & ~clear;
    if (clear || expire || (state_q == HOLD && value_ack)) begin
      state_d = IDLE;
      entry_d = '0;
      sel_d = START;
      cnt_d = '0;
    end else if (accept) begin
      entry_d[{sel_q, 2'b00} +: 4] = digit_in;
      sel_d = MSD_FIRST ? sel_q - 2'd1 : sel_q + 2'd1;
      state_d = sel_q == TERM ? HOLD : FILL;
      value_d = sel_q == TERM ? entry_d : value_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      entry_q <= '0;
      value_q <= '0;
      sel_q <= START;
      cnt_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      value_q <= value_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end
  assign dig_sel = sel_q;
  assign entry = entry_q;
  assign value_out = value_q;
  assign value_valid = state_q == HOLD;
  assign timeout = timeout_q;
  assign overrun = overrun_q;
endmodule

// File: tb/tb_digit_assembler.sv
// tb_digit_assembler: checks an MSD-first/timeout instance and an LSD-first/no-timeout instance against a digit-count model
module tb_digit_assembler;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] digit_in = '0;
  logic digit_valid = 1'b0, clear = 1'b0, value_ack = 1'b0;
  logic ready_a, value_valid_a, timeout_a, overrun_a;
  logic [1:0] dig_sel_a;
  logic [15:0] entry_a, value_out_a;
  logic ready_b, value_valid_b, timeout_b, overrun_b;
  logic [1:0] dig_sel_b;
  logic [15:0] entry_b, value_out_b;
  int checks = 0, errors = 0;
  int held[2], idle[2];
  logic [15:0] m_ent[2], m_val[2];
  bit m_to[2], m_ov[2];

  always #5 clk = ~clk;

  digit_assembler #(.MSD_FIRST(1'b1), .TIMEOUT_CYCLES(8), .TO_W(24)) dut_a (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .value_ack(value_ack), .ready(ready_a), .dig_sel(dig_sel_a), .entry(entry_a),
    .value_out(value_out_a), .value_valid(value_valid_a), .timeout(timeout_a), .overrun(overrun_a));
  digit_assembler #(.MSD_FIRST(1'b0), .TIMEOUT_CYCLES(0), .TO_W(24)) dut_b (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid), .clear(clear),
    .value_ack(value_ack), .ready(ready_b), .dig_sel(dig_sel_b), .entry(entry_b),
    .value_out(value_out_b), .value_valid(value_valid_b), .timeout(timeout_b), .overrun(overrun_b));

  function automatic logic [37:0] obs_of(int m);
    return m == 0 ? {ready_a, dig_sel_a, entry_a, value_out_a, value_valid_a, timeout_a, overrun_a}
                  : {ready_b, dig_sel_b, entry_b, value_out_b, value_valid_b, timeout_b, overrun_b};
  endfunction

  function automatic logic [37:0] exp_of(int m);
    int p = held[m] % 4;
    logic [1:0] sel = 2'(m == 0 ? 3 - p : p);
    return {held[m] != 4, sel, m_ent[m], m_val[m], held[m] == 4, m_to[m], m_ov[m]};
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      held[m] = 0; idle[m] = 0; m_ent[m] = '0; m_val[m] = '0; m_to[m] = 0; m_ov[m] = 0;
    end
  endfunction

  // digit m of an entry lands at group (3-n) for MSD-first, n otherwise
  function automatic void model_step(int m);
    int tc = m == 0 ? 8 : 0;
    int pos = m == 0 ? 3 - held[m] : held[m];
    logic [15:0] mk;
    m_to[m] = 0; m_ov[m] = 0;
    if (clear) begin
      held[m] = 0; m_ent[m] = '0; idle[m] = 0;
    end else if (held[m] == 4) begin
      m_ov[m] = digit_valid;
      if (value_ack) begin held[m] = 0; m_ent[m] = '0; end
    end else if (digit_valid) begin
      mk = 16'hF << (4 * pos);
      m_ent[m] = (m_ent[m] & ~mk) | (16'(digit_in) << (4 * pos));
      held[m]++; idle[m] = 0;
      if (held[m] == 4) m_val[m] = m_ent[m];
    end else if (held[m] > 0 && tc > 0) begin
      idle[m]++;
      if (idle[m] == tc) begin held[m] = 0; m_ent[m] = '0; idle[m] = 0; m_to[m] = 1; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0); model_step(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 model_reset();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL reset inst%0d got=%h exp=%h", m, obs_of(m), exp_of(m)); end
    end
    checks++;
    if ({ready_a, dig_sel_a, dig_sel_b} !== 5'b1_11_00) begin errors++; $display("FAIL reset_sel got=%b exp=11100", {ready_a, dig_sel_a, dig_sel_b}); end
    rst = 1'b0;
  endtask

  task automatic test_msd_first();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dig_sel_a !== 2'(3 - i)) begin errors++; $display("FAIL msd_sel%0d got=%b exp=%b", i, dig_sel_a, 2'(3 - i)); end
      digit_valid = 1'b1; digit_in = 4'(i + 1);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL msd_step inst%0d got=%h exp=%h", m, obs_of(m), exp_of(m)); end
      end
    end
    digit_valid = 1'b0;
    checks++;
    if ({value_out_a, value_valid_a, ready_a, value_out_b} !== {16'h1234, 2'b10, 16'h4321}) begin
      errors++; $display("FAIL msd_commit got=%h/%b%b/%h exp=1234/10/4321", value_out_a, value_valid_a, ready_a, value_out_b);
    end
  endtask

  task automatic test_overrun();
    digit_valid = 1'b1; digit_in = 4'h5;
    tick();
    digit_valid = 1'b0;
    checks++;
    if ({overrun_a, value_out_a} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL overrun_pulse got=%b/%h exp=1/1234", overrun_a, value_out_a); end
    tick();
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL overrun_single got=%b exp=0", overrun_a); end
    value_ack = 1'b1;
    tick();
    value_ack = 1'b0;
    checks++;
    if ({value_valid_a, ready_a, entry_a, dig_sel_a, value_out_a} !== {2'b01, 16'h0, 2'b11, 16'h1234}) begin
      errors++; $display("FAIL ack got=%b%b/%h/%b/%h exp=01/0000/11/1234", value_valid_a, ready_a, entry_a, dig_sel_a, value_out_a);
    end
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL ack_model inst%0d got=%h exp=%h", m, obs_of(m), exp_of(m)); end
    end
  endtask

  task automatic test_lsd_first();
    for (int i = 0; i < 4; i++) begin
      digit_valid = 1'b1; digit_in = 4'(10 + i);
      tick();
      if (i == 1) begin
        checks++;
        if (entry_b !== 16'h00BA) begin errors++; $display("FAIL lsd_entry got=%h exp=00ba", entry_b); end
      end
    end
    digit_valid = 1'b0;
    checks++;
    if ({value_out_b, value_out_a} !== {16'hDCBA, 16'hABCD}) begin errors++; $display("FAIL lsd_commit got=%h/%h exp=dcba/abcd", value_out_b, value_out_a); end
    value_ack = 1'b1;
    tick();
    value_ack = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL lsd_model inst%0d got=%h exp=%h", m, obs_of(m), exp_of(m)); end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    for (int r = 0; r < 2; r++) begin
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 2; i++) begin digit_valid = 1'b1; digit_in = 4'(i + 1); tick(); end
      digit_valid = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
        digit_valid = (r == 1 && i == 7); digit_in = 4'h3;
        tick();
        pulses += int'(timeout_a);
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL timeout_model r%0d inst%0d got=%h exp=%h", r, m, obs_of(m), exp_of(m)); end
        end
      end
      digit_valid = 1'b0;
      tick();
      pulses += int'(timeout_a);
      checks++;
      if (r == 0 && {pulses, entry_a, ready_a, dig_sel_a, value_out_a} !== {32'd1, 16'h0, 1'b1, 2'b11, 16'hABCD}) begin
        errors++; $display("FAIL timeout_abort got=%0d/%h/%b/%b/%h exp=1/0000/1/11/abcd", pulses, entry_a, ready_a, dig_sel_a, value_out_a);
      end else if (r == 1 && {pulses, entry_a, dig_sel_a} !== {32'd0, 16'h1230, 2'b00}) begin
        errors++; $display("FAIL timeout_saved got=%0d/%h/%b exp=0/1230/00", pulses, entry_a, dig_sel_a);
      end
    end
  endtask

  task automatic test_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 3; i++) begin digit_valid = 1'b1; digit_in = 4'(7 + i); tick(); end
    clear = 1'b1; digit_in = 4'hF;
    tick();
    clear = 1'b0; digit_valid = 1'b0;
    checks++;
    if ({entry_a, dig_sel_a, value_valid_a, entry_b, dig_sel_b, value_valid_b} !== {16'h0, 3'b110, 16'h0, 3'b000}) begin
      errors++; $display("FAIL clear got=%h/%b/%b %h/%b/%b exp=0000/11/0 0000/00/0", entry_a, dig_sel_a, value_valid_a, entry_b, dig_sel_b, value_valid_b);
    end
    tick();
    checks++;
    if ({overrun_a, overrun_b, value_out_a} !== {2'b00, 16'hABCD}) begin errors++; $display("FAIL clear_nocommit got=%b%b/%h exp=00/abcd", overrun_a, overrun_b, value_out_a); end
  endtask

  task automatic test_async_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < (r == 0 ? 2 : 4); i++) begin digit_valid = 1'b1; digit_in = 4'(i + 2); tick(); end
      digit_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1 model_reset();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL async_rst r%0d inst%0d got=%h exp=%h", r, m, obs_of(m), exp_of(m)); end
      end
      #1 rst = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin digit_valid = 1'b1; digit_in = 4'(9 - i); tick(); end
    digit_valid = 1'b0;
    checks++;
    if ({value_out_a, value_valid_a} !== {16'h9876, 1'b1}) begin errors++; $display("FAIL post_rst got=%h/%b exp=9876/1", value_out_a, value_valid_a); end
    value_ack = 1'b1; tick(); value_ack = 1'b0;
  endtask

  task automatic test_random();
    int rate = 2;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) rate = $urandom_range(1, 12);
      digit_valid = ($urandom_range(0, rate - 1) == 0);
      digit_in = 4'($urandom);
      clear = ($urandom_range(0, 29) == 0);
      value_ack = ($urandom_range(0, 3) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (obs_of(m) !== exp_of(m)) begin errors++; $display("FAIL random c%0d inst%0d got=%h exp=%h", i, m, obs_of(m), exp_of(m)); end
      end
    end
    digit_valid = 1'b0; clear = 1'b0; value_ack = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_msd_first();
    test_overrun();
    test_lsd_first();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/digit_assembler.md
Name: digit_assembler

Overview:
- Reverse of the display digit-group selection path: accepts 4-bit digits one at a time and packs them into a 16-bit value made of four nibble groups.
- Position codes are 00 = bits [3:0], 01 = [7:4], 10 = [11:8], 11 = [15:12].
- Sits between a digit source (keypad decoder / serial nibble feed) and the 16-bit value consumed by the display and datapath.
- Provides a live partial-entry view, a committed value with a valid/ack handshake, and an inactivity timeout.

Parameters:
- MSD_FIRST, 1, 1 = first digit goes to group 11 and the count runs down to 00; 0 = first digit goes to group 00 and the count runs up to 11.
- TIMEOUT_CYCLES, 0, clocks of inactivity during a partial entry before it is aborted; 0 disables the timeout.
- TO_W, 24, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- digit_in  input  4  digit nibble to store.
- digit_valid  input  1  digit_in is presented this cycle.
- clear  input  1  synchronous abort of the entry in progress.
- value_ack  input  1  consumer has taken value_out.
- ready  output  1  a digit_valid this cycle will be accepted.
- dig_sel  output  2  group position the next accepted digit will be written to.
- entry  output  16  live assembly register, for the display while the user types.
- value_out  output  16  last committed 4-digit value.
- value_valid  output  1  value_out holds an unacknowledged committed value.
- timeout  output  1  one-cycle pulse when a partial entry is aborted by inactivity.
- overrun  output  1  one-cycle pulse when digit_valid arrives while ready=0.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, entry=0, value_out=0, value_valid=0, ready=1.
  - dig_sel = 11 if MSD_FIRST else 00.
  - timeout=0, overrun=0, timeout counter=0.
- States: IDLE (no digits held), FILL (1–3 digits held), HOLD (commit pending ack).
- Digit accept: digit_valid & ready & !clear at a rising edge.
  - Writes digit_in into the entry nibble at dig_sel; all other nibbles are unchanged.
  - Steps dig_sel: down if MSD_FIRST, up otherwise, modulo 4.
  - Zero-latency accept: ready is combinational from state.
- IDLE → FILL on the 1st accepted digit. At the start of a new entry, nibbles not yet written read as 0.
- FILL → FILL on the 2nd and 3rd accepted digits.
- FILL → HOLD on the 4th accepted digit, i.e. the digit written at the terminal position (00 when MSD_FIRST, 11 otherwise).
  - In that same edge: value_out ← completed word, including the 4th digit.
  - value_valid=1 and ready=0 from the next cycle.
  - entry retains the full word.
- HOLD → IDLE on value_ack.
  - Next cycle: value_valid=0, ready=1, entry=0, dig_sel back to its start position.
  - value_out keeps the committed word until the next commit.
- value_ack while value_valid=0 is ignored.
- clear, any state → IDLE: entry=0, dig_sel=start position, value_valid=0, timeout counter=0.
  - value_out is unchanged.
  - clear has priority over digit_valid and value_ack in the same cycle; the digit is discarded and overrun is not pulsed.
- overrun: pulses for one cycle after any cycle with digit_valid=1, ready=0, clear=0 (HOLD state). The digit is dropped and state is unchanged.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter runs only in FILL and resets to 0 on every accepted digit.
  - When it reaches TIMEOUT_CYCLES-1 with no digit that cycle, the next state is IDLE, as for clear, and timeout pulses high for exactly one cycle.
  - A digit accepted in the terminal-count cycle wins: no timeout.
  - Counter held at 0 in IDLE and HOLD.
  - With TIMEOUT_CYCLES=0 the counter and pulse are never active.
- Back-to-back: digit_valid may stay high every cycle. Four consecutive cycles commit, and the 5th cycle shows overrun.
- rst asserted mid-entry or in HOLD returns immediately to reset values; no partial commit.

Test Plan:
- Reset then MSD_FIRST=1, digits 1,2,3,4 on consecutive cycles → dig_sel 11,10,01,00; value_out=0x1234 and value_valid=1 one cycle after the 4th digit; ready=0.
- MSD_FIRST=0, digits A,B,C,D → value_out=0xDCBA; entry after 2 digits reads 0x00BA.
- HOLD with 0x1234, drive digit 5 → overrun single pulse, value_out stays 0x1234. Then value_ack → value_valid=0, ready=1, entry=0, dig_sel=11.
- TIMEOUT_CYCLES=8: enter 2 digits, then idle 8 cycles → timeout pulse once, entry=0, state IDLE, value_out unchanged. Repeat with a digit on the 8th idle cycle → no timeout, 3 digits held.
- After 3 digits, assert clear and digit_valid together → entry=0, dig_sel=start, no commit, no overrun.
- Assert rst asynchronously mid-cycle in FILL and in HOLD → all outputs at reset values before the next clk edge; new entry 9,8,7,6 → 0x9876.
